// File: rtl/dimm_ctrl_pkg.sv
// rtl/dimm_ctrl_pkg.sv - shared types and A-bus bit positions for the DIMM command sequencer
package dimm_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_RD    = 2'd0,
        OP_WR    = 2'd1,
        OP_CLONE = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_WAIT_LAT,
        S_BURST,
        S_WAIT_WR,
        S_PRE,
        S_WAIT_RP,
        S_ACT2,
        S_WAIT_ACT2
    } state_t;

    // Command encoding bits on the shared A bus
    localparam int RAS_N_BIT = 16;
    localparam int CAS_N_BIT = 15;
    localparam int WE_N_BIT  = 14;
    localparam int AP_BIT    = 10;

    // Width of the shared timing counter; covers every programmable delay
    localparam int TIMER_W = 8;

endpackage

// File: rtl/dimm_cmd_timer.sv
// rtl/dimm_cmd_timer.sv - loadable down-counter with zero flag for command spacing
module dimm_cmd_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dimm_cmd_sequencer.sv
// rtl/dimm_cmd_sequencer.sv - closed-page DDR4 command sequencer; RowClone FPM enabled by ROWCLONE_EN
module dimm_cmd_sequencer
    import dimm_ctrl_pkg::*;
#(
    parameter int  RANKS     = 1,
    parameter int  BGWIDTH   = 2,
    parameter int  BAWIDTH   = 2,
    parameter int  ADDRWIDTH = 17,
    parameter int  COLWIDTH  = 10,
    parameter int  BL        = 8,
    parameter int  TRCD      = 15,
    parameter int  TCL       = 15,
    parameter int  TCWL      = 12,
    parameter int  TWR       = 12,
    parameter int  TRP       = 15,
    localparam int RW        = (RANKS > 1) ? $clog2(RANKS) : 1,
    localparam int BEATW     = (BL > 1) ? $clog2(BL) : 1
) (
    input  logic                 ck_t,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [RW-1:0]        req_rank,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [ADDRWIDTH-1:0] req_row2,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic [RANKS-1:0]     cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 wr_drive,
    output logic                 rd_capture,
    output logic [BEATW-1:0]     beat,
    output logic                 done,
    output logic                 resp_err
);

    // Every wait is "load delay-1 on entry, advance when the counter reads zero"
    localparam logic [TIMER_W-1:0] LD_RCD = TIMER_W'(TRCD - 1);
    localparam logic [TIMER_W-1:0] LD_CL  = TIMER_W'(TCL - 1);
    localparam logic [TIMER_W-1:0] LD_CWL = TIMER_W'(TCWL - 1);
    localparam logic [TIMER_W-1:0] LD_BL  = TIMER_W'(BL - 1);
    localparam logic [TIMER_W-1:0] LD_WR  = (TWR > 1) ? TIMER_W'(TWR - 2) : '0;
    localparam logic [TIMER_W-1:0] LD_RP  = TIMER_W'(TRP - 1);

    state_t                 state, state_n;
    op_t                    op_q;
    logic [RW-1:0]          rank_q;
    logic [BGWIDTH-1:0]     bg_q;
    logic [BAWIDTH-1:0]     ba_q;
    logic [ADDRWIDTH-1:0]   row_q;
    logic [ADDRWIDTH-1:0]   act2_row;
    logic [COLWIDTH-1:0]    col_q;
    logic [RANKS-1:0]       rank_sel;
    logic                   load;
    logic [TIMER_W-1:0]     load_val;
    logic [TIMER_W-1:0]     count;
    logic                   zero;
    logic                   done_q, err_q, done_n, err_n;
    logic                   legal, accept, is_wr, is_clone;

    assign is_wr    = (op_q == OP_WR);
    assign is_clone = (op_q == OP_CLONE);
    assign accept   = (state == S_IDLE) && req_valid;

`ifdef ROWCLONE_EN
    logic [ADDRWIDTH-1:0] row2_q;

    assign legal    = (op_t'(req_op) != OP_RSVD);
    assign act2_row = row2_q;

    // Clone destination row is only needed when RowClone is built in
    always_ff @(posedge ck_t) begin
        if (reset) begin
            row2_q <= '0;
        end else if (accept) begin
            row2_q <= req_row2;
        end
    end
`else
    logic unused_row2;

    assign legal       = (op_t'(req_op) == OP_RD) || (op_t'(req_op) == OP_WR);
    assign act2_row    = '0;
    assign unused_row2 = ^req_row2;
`endif

    dimm_cmd_timer #(.W(TIMER_W)) u_timer (
        .clk      (ck_t),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .zero     (zero)
    );

    // State register plus registered completion pulse
    always_ff @(posedge ck_t) begin
        if (reset) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    // Capture the whole request on the accepting edge; held until the next accept
    always_ff @(posedge ck_t) begin
        if (reset) begin
            op_q   <= OP_RD;
            rank_q <= '0;
            bg_q   <= '0;
            ba_q   <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (accept) begin
            op_q   <= op_t'(req_op);
            rank_q <= req_rank;
            bg_q   <= req_bg;
            ba_q   <= req_ba;
            row_q  <= req_row;
            col_q  <= req_col;
        end
    end

    // Next-state and timer loads; command states fall through their wait state when the delay is 1
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = '0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        state_n  = S_ACT;
                        load     = 1'b1;
                        load_val = LD_RCD;
                    end else begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end
                end
            end
            S_ACT, S_WAIT_RCD: begin
                if (zero) begin
                    load = 1'b1;
                    if (is_clone) begin
                        state_n  = S_ACT2;
                        load_val = LD_RCD;
                    end else begin
                        state_n  = S_CAS;
                        load_val = is_wr ? LD_CWL : LD_CL;
                    end
                end else begin
                    state_n = S_WAIT_RCD;
                end
            end
            S_CAS, S_WAIT_LAT: begin
                if (zero) begin
                    state_n  = S_BURST;
                    load     = 1'b1;
                    load_val = LD_BL;
                end else begin
                    state_n = S_WAIT_LAT;
                end
            end
            S_BURST: begin
                if (zero) begin
                    load = 1'b1;
                    if (is_wr && (TWR > 1)) begin
                        state_n  = S_WAIT_WR;
                        load_val = LD_WR;
                    end else begin
                        state_n  = S_PRE;
                        load_val = LD_RP;
                    end
                end
            end
            S_WAIT_WR, S_ACT2, S_WAIT_ACT2: begin
                if (zero) begin
                    state_n  = S_PRE;
                    load     = 1'b1;
                    load_val = LD_RP;
                end else if (state != S_WAIT_WR) begin
                    state_n = S_WAIT_ACT2;
                end
            end
            S_PRE, S_WAIT_RP: begin
                if (zero) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_WAIT_RP;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Active-low select for the captured rank
    always_comb begin
        rank_sel = '1;
        for (int r = 0; r < RANKS; r++) begin
            if (RW'(r) == rank_q) begin
                rank_sel[r] = 1'b0;
            end
        end
    end

    // Bus decode from state; reset forces the idle/deselect pattern in the same cycle
    always_comb begin
        cs_n       = '1;
        act_n      = 1'b1;
        A          = '0;
        bg         = '0;
        ba         = '0;
        wr_drive   = 1'b0;
        rd_capture = 1'b0;
        beat       = '0;
        done       = 1'b0;
        resp_err   = 1'b0;
        req_ready  = 1'b1;
        if (!reset) begin
            req_ready = (state == S_IDLE);
            done      = done_q;
            resp_err  = err_q;
            if (state != S_IDLE) begin
                bg = bg_q;
                ba = ba_q;
            end
            case (state)
                S_ACT: begin
                    cs_n  = rank_sel;
                    act_n = 1'b0;
                    A     = row_q;
                end
                S_ACT2: begin
                    cs_n  = rank_sel;
                    act_n = 1'b0;
                    A     = act2_row;
                end
                S_CAS: begin
                    cs_n              = rank_sel;
                    A[RAS_N_BIT]      = 1'b1;
                    A[CAS_N_BIT]      = 1'b0;
                    A[WE_N_BIT]       = ~is_wr;
                    A[COLWIDTH-1:0]   = col_q;
                end
                S_BURST: begin
                    wr_drive   = is_wr;
                    rd_capture = ~is_wr;
                    beat       = BEATW'(LD_BL - count);
                end
                S_PRE: begin
                    cs_n         = rank_sel;
                    A[CAS_N_BIT] = 1'b1;
                    A[AP_BIT]    = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dimm_cmd_sequencer.sv
// tb/tb_dimm_cmd_sequencer.sv - randomized self-checking bench for dimm_cmd_sequencer
module tb_dimm_cmd_sequencer;

    localparam int TRCD = 15;
    localparam int TCL  = 15;
    localparam int TCWL = 12;
    localparam int TWR  = 12;
    localparam int TRP  = 15;
    localparam int BL   = 8;
`ifdef ROWCLONE_EN
    localparam bit CLONE_ON = 1'b1;
`else
    localparam bit CLONE_ON = 1'b0;
`endif

    logic        ck_t = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [0:0]  req_rank = '0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [16:0] req_row2 = '0;
    logic [9:0]  req_col = '0;
    logic [0:0]  cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        wr_drive;
    logic        rd_capture;
    logic [2:0]  beat;
    logic        done;
    logic        resp_err;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [0:0]  cs_n;
        logic        act_n;
        logic [16:0] a;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic        wr_drive;
        logic        rd_capture;
        logic [2:0]  beat;
        logic        done;
        logic        resp_err;
        logic        req_ready;
    } outs_t;

    typedef struct {
        int op;
        int bg;
        int ba;
        int row;
        int row2;
        int col;
    } req_t;

    dimm_cmd_sequencer #(
        .RANKS(1), .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10), .BL(BL),
        .TRCD(TRCD), .TCL(TCL), .TCWL(TCWL), .TWR(TWR), .TRP(TRP)
    ) dut (
        .ck_t(ck_t), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_row2(req_row2), .req_col(req_col),
        .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
        .wr_drive(wr_drive), .rd_capture(rd_capture), .beat(beat),
        .done(done), .resp_err(resp_err)
    );

    always #5 ck_t = ~ck_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic outs_t sample();
        outs_t o;
        o = {cs_n, act_n, A, bg, ba, wr_drive, rd_capture, beat, done, resp_err, req_ready};
        return o;
    endfunction

    function automatic outs_t idle_out();
        outs_t e;
        e = '0;
        e.cs_n = 1'b1;
        e.act_n = 1'b1;
        e.req_ready = 1'b1;
        return e;
    endfunction

    // Cycles from acceptance to the done pulse, straight from the timing rules
    function automatic int txn_len(input req_t r);
        if (r.op == 3 || (r.op == 2 && !CLONE_ON)) return 1;
        if (r.op == 2) return 1 + 2 * TRCD + TRP;
        if (r.op == 1) return 1 + TRCD + TCWL + (BL - 1) + TWR + TRP;
        return 1 + TRCD + TCL + BL + TRP;
    endfunction

    // Expected bus contents k cycles after the accepting edge
    function automatic outs_t model(input req_t r, input int k);
        outs_t e;
        int    len, t_d0, t_pre;
        bit    clone, wr, legal;
        clone = (r.op == 2) && CLONE_ON;
        wr    = (r.op == 1);
        legal = (r.op < 2) || clone;
        len   = txn_len(r);
        e = '0;
        e.cs_n = 1'b1;
        e.act_n = 1'b1;
        if (k == len) begin
            e.done = 1'b1;
            e.resp_err = !legal;
            e.req_ready = 1'b1;
            return e;
        end
        e.bg = 2'(r.bg);
        e.ba = 2'(r.ba);
        t_pre = clone ? 1 + 2 * TRCD : len - TRP;
        t_d0  = 1 + TRCD + (wr ? TCWL : TCL);
        if (k == 1) begin
            e.cs_n = 1'b0; e.act_n = 1'b0; e.a = 17'(r.row);
        end else if (clone && k == 1 + TRCD) begin
            e.cs_n = 1'b0; e.act_n = 1'b0; e.a = 17'(r.row2);
        end else if (!clone && k == 1 + TRCD) begin
            e.cs_n = 1'b0;
            e.a = 17'h10000 | (wr ? 17'h0 : 17'h04000) | 17'(r.col);
        end else if (k == t_pre) begin
            e.cs_n = 1'b0; e.a = 17'h08000;
        end
        if (!clone && k >= t_d0 && k < t_d0 + BL) begin
            if (wr) e.wr_drive = 1'b1;
            else    e.rd_capture = 1'b1;
            e.beat = 3'(k - t_d0);
        end
        return e;
    endfunction

    function automatic req_t rand_req(input int op);
        req_t r;
        r.op   = op;
        r.bg   = $urandom_range(0, 3);
        r.ba   = $urandom_range(0, 3);
        r.row  = $urandom_range(0, 131071);
        r.row2 = $urandom_range(0, 131071);
        r.col  = $urandom_range(0, 1023);
        return r;
    endfunction

    task automatic drive(input req_t r);
        req_valid = 1'b1;
        req_op    = 2'(r.op);
        req_bg    = 2'(r.bg);
        req_ba    = 2'(r.ba);
        req_row   = 17'(r.row);
        req_row2  = 17'(r.row2);
        req_col   = 10'(r.col);
    endtask

    task automatic test_reset();
        outs_t obs;
        reset = 1'b1;
        repeat (3) begin
            @(negedge ck_t);
            obs = sample();
            checks++;
            if (obs !== idle_out()) begin
                failures++;
                $display("FAIL reset_state got=%h exp=%h", obs, idle_out());
            end
        end
        reset = 1'b0;
        @(negedge ck_t);
        obs = sample();
        checks++;
        if (obs !== idle_out()) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", obs, idle_out());
        end
    endtask

    task automatic test_directed();
        req_t  r;
        outs_t obs, exp;
        for (int t = 0; t < 2; t++) begin
            r = '{op: (t == 0) ? 1 : 0, bg: 1, ba: 1, row: 1, row2: 0, col: 2};
            drive(r);
            @(posedge ck_t);
            for (int k = 1; k <= txn_len(r); k++) begin
                @(negedge ck_t);
                req_valid = 1'b0;
                obs = sample();
                exp = model(r, k);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL directed op=%0d k=%0d got=%h exp=%h", r.op, k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        req_t  r;
        outs_t obs, exp;
        int    gap;
        for (int t = 0; t < 8; t++) begin
            r = rand_req($urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge ck_t);
                obs = sample();
                checks++;
                if (obs !== idle_out()) begin
                    failures++;
                    $display("FAIL random_gap t=%0d got=%h exp=%h", t, obs, idle_out());
                end
            end
            drive(r);
            @(posedge ck_t);
            for (int k = 1; k <= txn_len(r); k++) begin
                @(negedge ck_t);
                req_valid = 1'b0;
                obs = sample();
                exp = model(r, k);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL random t=%0d op=%0d k=%0d got=%h exp=%h", t, r.op, k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        req_t  r1, r2;
        outs_t obs, exp;
        r1 = rand_req(1);
        r2 = rand_req(0);
        drive(r1);
        @(posedge ck_t);
        for (int k = 1; k <= txn_len(r1); k++) begin
            @(negedge ck_t);
            obs = sample();
            exp = model(r1, k);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL b2b_first k=%0d got=%h exp=%h", k, obs, exp);
            end
            drive(r2);
        end
        for (int k = 1; k <= txn_len(r2); k++) begin
            @(negedge ck_t);
            req_valid = 1'b0;
            obs = sample();
            exp = model(r2, k);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL b2b_second k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_t  r;
        outs_t obs, exp;
        r = rand_req(1);
        drive(r);
        @(posedge ck_t);
        for (int k = 1; k <= 1 + TRCD; k++) begin
            @(negedge ck_t);
            req_valid = 1'b0;
            obs = sample();
            exp = model(r, k);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_mid_pre k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        reset = 1'b1;
        #1;
        obs = sample();
        checks++;
        if (obs !== idle_out()) begin
            failures++;
            $display("FAIL reset_mid_forced got=%h exp=%h", obs, idle_out());
        end
        @(negedge ck_t);
        reset = 1'b0;
        for (int c = 0; c < TCWL + BL + TWR + TRP + 4; c++) begin
            obs = sample();
            checks++;
            if (obs !== idle_out()) begin
                failures++;
                $display("FAIL reset_mid_idle c=%0d got=%h exp=%h", c, obs, idle_out());
            end
            @(negedge ck_t);
        end
    endtask

    task automatic test_special_ops();
        req_t  r;
        outs_t obs, exp;
        for (int op = 2; op <= 3; op++) begin
            r = rand_req(op);
            if (op == 2) begin
                r.row = 1;
                r.row2 = 4;
            end
            drive(r);
            @(posedge ck_t);
            for (int k = 1; k <= txn_len(r); k++) begin
                @(negedge ck_t);
                req_valid = 1'b0;
                obs = sample();
                exp = model(r, k);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL special op=%0d k=%0d got=%h exp=%h", op, k, obs, exp);
                end
            end
            repeat (3) begin
                @(negedge ck_t);
                obs = sample();
                checks++;
                if (obs !== idle_out()) begin
                    failures++;
                    $display("FAIL special_idle op=%0d got=%h exp=%h", op, obs, idle_out());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_special_ops();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dimm_cmd_sequencer.md
Name: dimm_cmd_sequencer

Overview: Closed-page DDR4 command sequencer driving the DIMM emulator's command/address bus. It accepts one read, write or (optionally) RowClone request at a time over a valid/ready handshake and issues ACT, then RD/WR, then PRE with programmable tRCD/tCL/tCWL/tWR/tRP spacing. It also generates the DQ drive window and read-capture window for the host-side datapath. It sits between the host request logic and the dimm instance.

Parameters:
RANKS, 1, number of ranks / cs_n width
BGWIDTH, 2, bank-group address width
BAWIDTH, 2, bank address width
ADDRWIDTH, 17, row/command address width (A bus)
COLWIDTH, 10, column address width
BL, 8, burst length in ck_t cycles
TRCD, 15, ACT to CAS in cycles (>=1)
TCL, 15, RD CAS to first read beat (>=1)
TCWL, 12, WR CAS to first write beat (>=1)
TWR, 12, last write beat to PRE (>=1)
TRP, 15, PRE to done (>=1)

Ports:
ck_t  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  sequencer idle, accepts request
req_op  in  2  0=read, 1=write, 2=clone, 3=reserved
req_rank  in  $clog2(RANKS) or 1  target rank
req_bg  in  BGWIDTH  bank group
req_ba  in  BAWIDTH  bank
req_row  in  ADDRWIDTH  row (clone: source row)
req_row2  in  ADDRWIDTH  clone destination row
req_col  in  COLWIDTH  column
cs_n  out  RANKS  chip selects, active low
act_n  out  1  DDR4 ACT_n
A  out  ADDRWIDTH  address/command bus (A16=RAS_n, A15=CAS_n, A14=WE_n)
bg  out  BGWIDTH  bank group
ba  out  BAWIDTH  bank
wr_drive  out  1  host drives dq/dqs this cycle
rd_capture  out  1  host samples dq this cycle
beat  out  $clog2(BL)  beat index in current burst
done  out  1  one-cycle completion pulse
resp_err  out  1  valid with done; illegal op

Behaviour:
- Reset (and any cycle with reset=1): state IDLE; cs_n all 1, act_n=1, A=0, bg=0, ba=0, wr_drive=0, rd_capture=0, beat=0, done=0, resp_err=0, req_ready=1. Reset mid-operation aborts immediately; no PRE is issued.
- NOP/deselect: cs_n all 1, act_n=1, A=0. bg/ba hold the captured request values for the whole operation.
- Accept: in IDLE, req_valid && req_ready captures all req_* fields; req_ready=0 until return to IDLE. req_valid while busy is ignored.
- FSM: IDLE -> ACT -> WAIT_RCD -> CAS -> WAIT_LAT -> BURST -> WAIT_WR (write only) -> PRE -> WAIT_RP -> IDLE.
- Cycle N = acceptance edge. Cycle N+1: ACT (cs_n[rank]=0, act_n=0, A=row). CAS exactly TRCD cycles after ACT: act_n=1, A16=1, A15=0, A14=~write, A[COLWIDTH-1:0]=col, other bits 0.
- Write: wr_drive=1 for BL consecutive cycles starting TCWL cycles after CAS; beat counts 0..BL-1. PRE issued TWR cycles after the last beat.
- Read: rd_capture=1 for BL cycles starting TCL cycles after CAS; beat counts 0..BL-1. PRE issued the cycle after the last beat.
- PRE: cs_n[rank]=0, act_n=1, A16=0, A15=1, A14=0, A10=0 (single bank). done pulses TRP cycles after PRE; req_ready=1 in the same cycle. A new request may be accepted on that edge.
- req_op=3 (or 2 without the macro): accepted, no commands issued, done=1 and resp_err=1 on cycle N+1.
- All timing uses one shared down-counter: load value-1, advance on zero.

Optional Feature:
ROWCLONE_EN. When defined, req_op=2 gives RowClone FPM: ACT row, then TRCD cycles later ACT req_row2 (same bank, no intervening PRE), then TRCD cycles later PRE, then TRP, then done with resp_err=0. No data window is opened. When undefined, op 2 is illegal (see above) and req_row2 is unused.

Decomposition:
- Package dimm_ctrl_pkg: op enum (OP_RD, OP_WR, OP_CLONE, OP_RSVD), FSM state enum, A-bus command bit indices (RAS_N_BIT=16, CAS_N_BIT=15, WE_N_BIT=14, AP_BIT=10).
- One sub-module: dimm_cmd_timer (loadable down-counter with zero flag), instantiated once.

Test Plan:
- Write rank0 bg=1 ba=1 row=1 col=2 -> ACT A=0x00001 at N+1; CAS A=0x10002 at N+16; wr_drive N+28..N+35; PRE A=0x08000 at N+47; done at N+62.
- Read same address -> CAS A=0x14002 at N+16; rd_capture N+31..N+38, beat 0..7; PRE at N+39; done at N+54.
- req_valid held during write -> req_ready=0 until done; second request accepted on the done edge, with its ACT on the next cycle.
- Reset asserted at the CAS cycle -> next cycle all outputs at reset values; no PRE; req_ready=1.
- ROWCLONE_EN, op=2, row=1, row2=4 -> ACT 0x00001 at N+1, ACT 0x00004 at N+16, PRE at N+31, done at N+46. Without the macro -> done=1 and resp_err=1 at N+1, cs_n stays all 1.
- op=3 -> done=1 and resp_err=1 at N+1, cs_n stays all 1.
